// File: rtl/dsp.sv
// dsp - single-slice multiply-accumulate block.
//   18-bit pre-adder/subtractor (D +/- B), 18x18 unsigned multiplier and a
//   48-bit post-adder/subtractor/accumulator. Every stage can be registered
//   or bypassed through its *REG parameter.
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   A, B, D, BCIN       18-bit operands and cascade B input
//   C, PCIN             48-bit adder operand and cascade P input
//   OPMODE              operation select
//   CARRYIN             external carry input
//   CE*                 per-stage clock enables
//   BCOUT               B path after the B1 stage
//   M                   multiplier product after the M stage
//   P, PCOUT            post-adder result
//   CARRYOUT, CARRYOUTF post-adder carry (borrow when subtracting)
module dsp #(
  parameter int    A0REG       = 0,
  parameter int    A1REG       = 1,
  parameter int    B0REG       = 0,
  parameter int    B1REG       = 1,
  parameter int    CREG        = 1,
  parameter int    DREG        = 1,
  parameter int    MREG        = 1,
  parameter int    PREG        = 1,
  parameter int    CARRYINREG  = 1,
  parameter int    CARRYOUTREG = 1,
  parameter int    OPMODEREG   = 1,
  parameter string CARRYINSEL  = "OPMODE5",
  parameter string B_INPUT     = "DIRECT"
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [17:0] A,
  input  logic [17:0] B,
  input  logic [17:0] D,
  input  logic [17:0] BCIN,
  input  logic [47:0] C,
  input  logic [47:0] PCIN,
  input  logic [7:0]  OPMODE,
  input  logic        CARRYIN,
  input  logic        CEA,
  input  logic        CEB,
  input  logic        CEC,
  input  logic        CED,
  input  logic        CEM,
  input  logic        CEP,
  input  logic        CECARRYIN,
  input  logic        CEOPMODE,
  output logic [17:0] BCOUT,
  output logic [35:0] M,
  output logic [47:0] P,
  output logic [47:0] PCOUT,
  output logic        CARRYOUT,
  output logic        CARRYOUTF
);

  logic [7:0]  opm_r, opm;
  logic [17:0] a0_r, a0, a1_r, a1;
  logic [17:0] b0_r, b0, b1_r, b1, b_src, pre, b1_in;
  logic [17:0] d_r, d_s;
  logic [47:0] c_r, c_s;
  logic [35:0] mult, m_r, m_s;
  logic        cyi_in, cyi_r, cyi;
  logic [47:0] x_mux, z_mux;
  logic [48:0] x_cin, post;
  logic [47:0] p_r, p_s;
  logic        cyo_r, cyo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opm_r <= '0;
      a0_r  <= '0;
      a1_r  <= '0;
      b0_r  <= '0;
      b1_r  <= '0;
      d_r   <= '0;
      c_r   <= '0;
      m_r   <= '0;
      cyi_r <= 1'b0;
      p_r   <= '0;
      cyo_r <= 1'b0;
    end else begin
      if (CEOPMODE)  opm_r <= OPMODE;
      if (CEA)       a0_r  <= A;
      if (CEA)       a1_r  <= a0;
      if (CEB)       b0_r  <= b_src;
      if (CEB)       b1_r  <= b1_in;
      if (CED)       d_r   <= D;
      if (CEC)       c_r   <= C;
      if (CEM)       m_r   <= mult;
      if (CECARRYIN) cyi_r <= cyi_in;
      if (CEP)       p_r   <= post[47:0];
      if (CECARRYIN) cyo_r <= post[48];
    end
  end

  assign opm = (OPMODEREG == 1) ? opm_r : OPMODE;

  // A path: two optional stages in series
  assign a0 = (A0REG == 1) ? a0_r : A;
  assign a1 = (A1REG == 1) ? a1_r : a0;

  // B path: source select, B0 stage, optional pre-adder, B1 stage
  assign b_src = (B_INPUT == "CASCADE") ? BCIN : B;
  assign b0    = (B0REG == 1) ? b0_r : b_src;
  assign d_s   = (DREG == 1) ? d_r : D;
  assign pre   = opm[6] ? (d_s - b0) : (d_s + b0);
  assign b1_in = opm[4] ? pre : b0;
  assign b1    = (B1REG == 1) ? b1_r : b1_in;

  assign c_s  = (CREG == 1) ? c_r : C;
  assign mult = 36'(b1) * 36'(a1);
  assign m_s  = (MREG == 1) ? m_r : mult;

  assign cyi_in = (CARRYINSEL == "CARRYIN") ? CARRYIN : opm[5];
  assign cyi    = (CARRYINREG == 1) ? cyi_r : cyi_in;

  always_comb begin
    x_mux = '0;
    case (opm[1:0])
      2'd0: x_mux = '0;
      2'd1: x_mux = {12'd0, m_s};
      2'd2: x_mux = p_s;
      2'd3: x_mux = {d_s[11:0], a1, b1};
      default: x_mux = '0;
    endcase
  end

  always_comb begin
    z_mux = '0;
    case (opm[3:2])
      2'd0: z_mux = '0;
      2'd1: z_mux = PCIN;
      2'd2: z_mux = p_s;
      2'd3: z_mux = c_s;
      default: z_mux = '0;
    endcase
  end

  // Carry-in joins X before the subtract, so bit 48 is a true borrow
  assign x_cin = {1'b0, x_mux} + {48'd0, cyi};
  assign post  = opm[7] ? ({1'b0, z_mux} - x_cin) : ({1'b0, z_mux} + x_cin);

  assign p_s = (PREG == 1) ? p_r : post[47:0];
  assign cyo = (CARRYOUTREG == 1) ? cyo_r : post[48];

  assign BCOUT     = b1;
  assign M         = m_s;
  assign P         = p_s;
  assign PCOUT     = p_s;
  assign CARRYOUT  = cyo;
  assign CARRYOUTF = cyo;

endmodule

// File: tb/tb_dsp.sv
module tb_dsp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [17:0] A, B, D, BCIN;
  logic [47:0] C, PCIN;
  logic [7:0]  OPMODE;
  logic        CARRYIN;
  logic        CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE;
  logic [17:0] BCOUT;
  logic [35:0] M;
  logic [47:0] P, PCOUT;
  logic        CARRYOUT, CARRYOUTF;

  int checks = 0;
  int passed = 0;

  dsp dut (
    .clk(clk), .rst_n(rst_n),
    .A(A), .B(B), .D(D), .BCIN(BCIN), .C(C), .PCIN(PCIN),
    .OPMODE(OPMODE), .CARRYIN(CARRYIN),
    .CEA(CEA), .CEB(CEB), .CEC(CEC), .CED(CED), .CEM(CEM), .CEP(CEP),
    .CECARRYIN(CECARRYIN), .CEOPMODE(CEOPMODE),
    .BCOUT(BCOUT), .M(M), .P(P), .PCOUT(PCOUT),
    .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ce(input logic v);
    CEA = v; CEB = v; CEC = v; CED = v; CEM = v; CEP = v;
    CECARRYIN = v; CEOPMODE = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  // Steady-state result of the slice for inputs held long enough, with no
  // P feedback selected. Carry-in comes from OPMODE[5].
  function automatic void model(input logic [17:0] a, b, d, input logic [47:0] c, pcin,
                                input logic [7:0] op, output logic [17:0] bc,
                                output logic [35:0] m, output logic [47:0] p,
                                output logic cy);
    longint unsigned x, z, cin, r;
    logic [47:0] cat;
    if (op[4]) bc = op[6] ? 18'(d - b) : 18'(d + b);
    else       bc = b;
    m = 36'(bc) * 36'(a);
    cat = {d[11:0], a, bc};
    case (op[1:0])
      2'd1:    x = longint'(m);
      2'd3:    x = longint'(cat);
      default: x = 0;
    endcase
    case (op[3:2])
      2'd1:    z = longint'(pcin);
      2'd3:    z = longint'(c);
      default: z = 0;
    endcase
    cin = longint'(op[5]);
    if (op[7]) begin
      r  = z - x - cin;
      cy = (z < x + cin);
    end else begin
      r  = z + x + cin;
      cy = r[48];
    end
    p = r[47:0];
  endfunction

  function automatic logic [7:0] rand_op();
    logic [7:0] op;
    op = 8'($urandom);
    if (op[1:0] == 2'd2) op[1:0] = 2'd3;
    if (op[3:2] == 2'd2) op[3:2] = 2'd1;
    return op;
  endfunction

  task automatic rand_inputs();
    A = 18'($urandom); B = 18'($urandom); D = 18'($urandom);
    BCIN = 18'($urandom); CARRYIN = 1'($urandom);
    C = {16'($urandom), 32'($urandom)};
    PCIN = {16'($urandom), 32'($urandom)};
  endtask

  task automatic test_reset();
    set_ce(1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_inputs();
      OPMODE = rand_op();
      tick(1);
    end
    tick(4);
    #2;
    rand_inputs();
    {CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE} = 8'($urandom);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({BCOUT, M, P, PCOUT, CARRYOUT, CARRYOUTF} !== '0)
      $display("FAIL reset_immediate: BCOUT=%0h M=%0h P=%0h PCOUT=%0h CY=%b CYF=%b expected all 0",
               BCOUT, M, P, PCOUT, CARRYOUT, CARRYOUTF);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      OPMODE = 8'($urandom);
      {CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE} = 8'($urandom);
      tick(1);
      checks++;
      if ({BCOUT, M, P, PCOUT, CARRYOUT, CARRYOUTF} !== '0)
        $display("FAIL reset_held: BCOUT=%0h M=%0h P=%0h PCOUT=%0h CY=%b CYF=%b expected all 0",
                 BCOUT, M, P, PCOUT, CARRYOUT, CARRYOUTF);
      else passed++;
    end
    rst_n = 1'b1;
    set_ce(1'b1);
  endtask

  task automatic test_presub();
    do_reset();
    A = 18'd20; B = 18'd10; D = 18'd25; C = 48'd350; PCIN = '0; CARRYIN = 1'b0;
    OPMODE = 8'b11011101;
    tick(2);
    checks++;
    if (BCOUT !== 18'd15) $display("FAIL presub_bcout: got %0d expected 15", BCOUT);
    else passed++;
    tick(1);
    checks++;
    if (M !== 36'd300) $display("FAIL presub_m: got %0d expected 300", M);
    else passed++;
    tick(1);
    checks++;
    if (P !== 48'd50 || PCOUT !== 48'd50)
      $display("FAIL presub_p: P=%0d PCOUT=%0d expected 50", P, PCOUT);
    else passed++;
    checks++;
    if (CARRYOUT !== 1'b0 || CARRYOUTF !== 1'b0)
      $display("FAIL presub_cy: CY=%b CYF=%b expected 0", CARRYOUT, CARRYOUTF);
    else passed++;
  endtask

  task automatic test_preadd();
    do_reset();
    A = 18'd20; B = 18'd10; D = 18'd25; C = 48'd350;
    OPMODE = 8'b00010000;
    tick(3);
    checks++;
    if (BCOUT !== 18'd35 || M !== 36'd700 || P !== 48'd0 || CARRYOUT !== 1'b0)
      $display("FAIL preadd: BCOUT=%0d M=%0d P=%0d CY=%b expected 35 700 0 0",
               BCOUT, M, P, CARRYOUT);
    else passed++;
  endtask

  task automatic test_bypass();
    do_reset();
    A = 18'd20; B = 18'd10; D = 18'd25; C = 48'd350;
    OPMODE = 8'b00001010;
    tick(3);
    checks++;
    if (BCOUT !== 18'd10 || M !== 36'd200 || P !== 48'd0)
      $display("FAIL bypass: BCOUT=%0d M=%0d P=%0d expected 10 200 0", BCOUT, M, P);
    else passed++;
  endtask

  task automatic test_concat();
    do_reset();
    A = 18'd5; B = 18'd6; D = 18'd25; C = '0; PCIN = 48'd3000; CARRYIN = 1'b0;
    OPMODE = 8'b10100111;
    tick(3);
    checks++;
    if (BCOUT !== 18'd6 || M !== 36'd30)
      $display("FAIL concat_bm: BCOUT=%0d M=%0d expected 6 30", BCOUT, M);
    else passed++;
    checks++;
    if (P !== 48'hFE6FFFEC0BB1 || PCOUT !== 48'hFE6FFFEC0BB1)
      $display("FAIL concat_p: P=%0h PCOUT=%0h expected fe6fffec0bb1", P, PCOUT);
    else passed++;
    checks++;
    if (CARRYOUT !== 1'b1 || CARRYOUTF !== 1'b1)
      $display("FAIL concat_cy: CY=%b CYF=%b expected 1", CARRYOUT, CARRYOUTF);
    else passed++;
  endtask

  // P(after n edges from reset) = (n-2) * A*B while accumulating M into P
  task automatic test_accumulate();
    int unsigned steps;
    longint unsigned acc;
    logic [47:0] exp_p;
    do_reset();
    A = 18'd5; B = 18'd6; D = 18'd25;
    OPMODE = 8'b00001001;
    tick(2);
    steps = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      steps++;
      exp_p = 48'(steps * 30);
      checks++;
      if (P !== exp_p) $display("FAIL accum_step%0d: P=%0d expected %0d", i, P, exp_p);
      else passed++;
    end
    CEP = 1'b0;
    tick(3);
    checks++;
    if (P !== 48'd90) $display("FAIL accum_cep_hold: P=%0d expected 90", P);
    else passed++;
    CEP = 1'b1;
    tick(1);
    checks++;
    if (P !== 48'd120 || CARRYOUT !== 1'b0)
      $display("FAIL accum_resume: P=%0d CY=%b expected 120 0", P, CARRYOUT);
    else passed++;
    for (int k = 0; k < 4; k++) begin
      do_reset();
      A = 18'($urandom); B = 18'($urandom); D = 18'($urandom);
      steps = $urandom_range(3, 10);
      tick(int'(steps));
      acc = longint'(steps - 2) * longint'(A) * longint'(B);
      exp_p = acc[47:0];
      checks++;
      if (P !== exp_p || PCOUT !== exp_p)
        $display("FAIL accum_rand%0d: P=%0h PCOUT=%0h expected %0h", k, P, PCOUT, exp_p);
      else passed++;
    end
  endtask

  task automatic test_random_steady();
    logic [17:0] ebc;
    logic [35:0] em;
    logic [47:0] ep;
    logic        ecy;
    set_ce(1'b1);
    for (int k = 0; k < 20; k++) begin
      rand_inputs();
      OPMODE = rand_op();
      tick(5);
      model(A, B, D, C, PCIN, OPMODE, ebc, em, ep, ecy);
      checks++;
      if (BCOUT !== ebc || M !== em || P !== ep || PCOUT !== ep ||
          CARRYOUT !== ecy || CARRYOUTF !== ecy)
        $display("FAIL steady%0d op=%b: BCOUT=%0h M=%0h P=%0h PCOUT=%0h CY=%b CYF=%b expected %0h %0h %0h %b",
                 k, OPMODE, BCOUT, M, P, PCOUT, CARRYOUT, CARRYOUTF, ebc, em, ep, ecy);
      else passed++;
    end
  endtask

  // Drop one enable, change the input it guards, and expect the old value
  // to keep driving everything downstream.
  task automatic test_ce_hold();
    logic [17:0] oa, ob, od, ebc;
    logic [47:0] oc, ep;
    logic [7:0]  oop, mop;
    logic [35:0] em;
    logic        ecy, ocy;
    for (int sel = 0; sel < 6; sel++) begin
      set_ce(1'b1);
      rand_inputs();
      OPMODE = rand_op();
      tick(5);
      oa = A; ob = B; od = D; oc = C; oop = OPMODE; ocy = CARRYOUT;
      case (sel)
        0: begin CEA = 1'b0; A = 18'($urandom); end
        1: begin CEB = 1'b0; B = 18'($urandom); end
        2: begin CED = 1'b0; D = 18'($urandom); end
        3: begin CEC = 1'b0; C = {16'($urandom), 32'($urandom)}; end
        4: begin CEOPMODE = 1'b0; OPMODE = rand_op(); end
        default: begin CECARRYIN = 1'b0; OPMODE[5] = ~OPMODE[5]; end
      endcase
      tick(5);
      mop = (sel == 4) ? oop : OPMODE;
      if (sel == 5) mop[5] = oop[5];
      model((sel == 0) ? oa : A, (sel == 1) ? ob : B, (sel == 2) ? od : D,
            (sel == 3) ? oc : C, PCIN, mop, ebc, em, ep, ecy);
      if (sel == 5) ecy = ocy;
      checks++;
      if (BCOUT !== ebc || M !== em || P !== ep || CARRYOUT !== ecy)
        $display("FAIL ce_hold%0d: BCOUT=%0h M=%0h P=%0h CY=%b expected %0h %0h %0h %b",
                 sel, BCOUT, M, P, CARRYOUT, ebc, em, ep, ecy);
      else passed++;
    end
    set_ce(1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    A = '0; B = '0; D = '0; BCIN = '0; C = '0; PCIN = '0;
    OPMODE = '0; CARRYIN = 1'b0;
    set_ce(1'b1);
    tick(2);
    rst_n = 1'b1;
    test_reset();
    test_presub();
    test_preadd();
    test_bypass();
    test_concat();
    test_accumulate();
    test_random_steady();
    test_ce_hold();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
